// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the VGA display path, the memory-port
// arbiter and the SDRAM controller.
//   FB_ADDR_W  : default pixel-offset width within one frame
//   FB_DATA_W  : default memory word width
//   fb_state_e : arbiter FSM states (idle, display burst, host write)
package fb_pkg;

    localparam int unsigned FB_ADDR_W = 22;
    localparam int unsigned FB_DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StDispBurst = 2'd1,
        StHostWr    = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_swap_ctl.sv
// Front/back buffer selection for the double-buffered frame store.
// A host swap request is remembered (pending), armed by the next top-of-screen
// pulse, and executed on the first cycle the memory port is quiet.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   swap_req_i : one-cycle swap request pulse
//   top_i      : one-cycle top-of-screen pulse
//   idle_i     : no display burst running and no reads outstanding
//   front_o    : buffer currently displayed
//   pending_o  : swap requested but not yet applied
//   exec_o     : swap executes this cycle (front_o toggles at the next edge)
module fb_swap_ctl (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic swap_req_i,
    input  logic top_i,
    input  logic idle_i,
    output logic front_o,
    output logic pending_o,
    output logic exec_o
);

    logic front_q, front_d;
    logic pending_q, pending_d;
    logic armed_q, armed_d;
    logic exec;

    assign exec = armed_q & idle_i;

    always_comb begin
        front_d   = front_q;
        pending_d = pending_q;
        armed_d   = armed_q;
        if (exec) begin
            front_d   = ~front_q;
            armed_d   = 1'b0;
            // A request landing on the execute cycle belongs to the next frame.
            pending_d = swap_req_i;
        end else begin
            pending_d = pending_q | swap_req_i;
            armed_d   = armed_q | (top_i & pending_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            front_q   <= front_d;
            pending_q <= pending_d;
            armed_q   <= armed_d;
        end
    end

    assign front_o   = front_q;
    assign pending_o = pending_q;
    assign exec_o    = exec;

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer memory-port arbiter and double-buffer scheduler.
// Shares one memory command port between display line-fetch bursts (always
// preferred) and single-word host pixel writes, and owns front/back buffer
// selection through fb_swap_ctl.
//   iCLK, iRST_N          : clock, synchronous active-low reset
//   iTopOfScreen          : top-of-screen pulse from the timing generator
//   iSwap_req             : swap request pulse; oSwap_pending, oFront status
//   iDisp_req/iDisp_addr  : display burst request; oDisp_grant accept pulse
//   oDisp_rvalid/rdata    : display read data, one register stage after memory
//   iHost_wr/addr/wdata   : host write request, held until oHost_ack
//   oMem_*                : registered memory command {buffer, offset}
//   iMem_ack              : command accepted; iMem_rvalid/rdata in-order returns
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W    = FB_ADDR_W,
    parameter int unsigned DATA_W    = FB_DATA_W,
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned MAX_OUT   = 16
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iTopOfScreen,
    input  logic              iSwap_req,
    output logic              oSwap_pending,
    output logic              oFront,
    input  logic              iDisp_req,
    input  logic [ADDR_W-1:0] iDisp_addr,
    output logic              oDisp_grant,
    output logic              oDisp_rvalid,
    output logic [DATA_W-1:0] oDisp_rdata,
    input  logic              iHost_wr,
    input  logic [ADDR_W-1:0] iHost_addr,
    input  logic [DATA_W-1:0] iHost_wdata,
    output logic              oHost_ack,
    output logic              oMem_req,
    output logic              oMem_we,
    output logic [ADDR_W:0]   oMem_addr,
    output logic [DATA_W-1:0] oMem_wdata,
    input  logic              iMem_ack,
    input  logic              iMem_rvalid,
    input  logic [DATA_W-1:0] iMem_rdata
);

    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);

    fb_state_e         state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              grant_q, grant_d;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic mem_ack;
    logic credit_ok;
    logic last_beat;
    logic cnt_inc;
    logic cnt_dec;
    logic swap_idle;
    logic swap_exec;
    logic front;
    logic front_nxt;
    logic pending;

    assign mem_ack   = iMem_ack & mem_req_q;
    assign credit_ok = (32'(out_cnt_q) + BURST_LEN) <= MAX_OUT;
    assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));

    // Reads become outstanding when accepted; a return with nothing
    // outstanding (e.g. left over from before a reset) is discarded.
    assign cnt_inc   = mem_ack & (state_q == StDispBurst);
    assign cnt_dec   = iMem_rvalid & (out_cnt_q != '0);
    assign out_cnt_d = out_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

    assign swap_idle = (state_q != StDispBurst) & (out_cnt_q == '0);

    fb_swap_ctl u_swap_ctl (
        .clk_i      (iCLK),
        .rst_ni     (iRST_N),
        .swap_req_i (iSwap_req),
        .top_i      (iTopOfScreen),
        .idle_i     (swap_idle),
        .front_o    (front),
        .pending_o  (pending),
        .exec_o     (swap_exec)
    );

    // Buffer selection that holds after this edge; a command latched in the
    // same cycle a swap executes must already target the new front/back.
    assign front_nxt = front ^ swap_exec;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (iDisp_req && credit_ok) begin
                    state_d    = StDispBurst;
                    grant_d    = 1'b1;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {front_nxt, iDisp_addr};
                end else if (iHost_wr) begin
                    state_d     = StHostWr;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {~front_nxt, iHost_addr};
                    mem_wdata_d = iHost_wdata;
                end
            end
            StDispBurst: begin
                if (mem_ack) begin
                    if (last_beat) begin
                        state_d   = StIdle;
                        mem_req_d = 1'b0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                        // Offset wraps within the frame; buffer bit is untouched.
                        mem_addr_d[ADDR_W-1:0] = mem_addr_q[ADDR_W-1:0] + ADDR_W'(1);
                    end
                end
            end
            StHostWr: begin
                if (mem_ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            out_cnt_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            out_cnt_q   <= out_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
            rvalid_q    <= cnt_dec;
            rdata_q     <= iMem_rdata;
        end
    end

    // Ack is combinational so the host sees it in the accept cycle and can drop
    // iHost_wr before the FSM, back in idle, would start a duplicate write.
    assign oHost_ack = (state_q == StHostWr) & mem_ack;

    assign oDisp_grant   = grant_q;
    assign oDisp_rvalid  = rvalid_q;
    assign oDisp_rdata   = rdata_q;
    assign oMem_req      = mem_req_q;
    assign oMem_we       = mem_we_q;
    assign oMem_addr     = mem_addr_q;
    assign oMem_wdata    = mem_wdata_q;
    assign oFront        = front;
    assign oSwap_pending = pending;

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;
    localparam int unsigned BL = 8;
    localparam int unsigned MO = 8;

    typedef struct packed {
        logic          we;
        logic [AW:0]   addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic          clk = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iTopOfScreen = 1'b0;
    logic          iSwap_req = 1'b0;
    logic          oSwap_pending;
    logic          oFront;
    logic          iDisp_req = 1'b0;
    logic [AW-1:0] iDisp_addr = '0;
    logic          oDisp_grant;
    logic          oDisp_rvalid;
    logic [DW-1:0] oDisp_rdata;
    logic          iHost_wr = 1'b0;
    logic [AW-1:0] iHost_addr = '0;
    logic [DW-1:0] iHost_wdata = '0;
    logic          oHost_ack;
    logic          oMem_req;
    logic          oMem_we;
    logic [AW:0]   oMem_addr;
    logic [DW-1:0] oMem_wdata;
    logic          iMem_ack = 1'b0;
    logic          iMem_rvalid = 1'b0;
    logic [DW-1:0] iMem_rdata = '0;

    always #5 clk = ~clk;

    fb_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_LEN (BL),
        .MAX_OUT   (MO)
    ) dut (
        .iCLK          (clk),
        .iRST_N        (iRST_N),
        .iTopOfScreen  (iTopOfScreen),
        .iSwap_req     (iSwap_req),
        .oSwap_pending (oSwap_pending),
        .oFront        (oFront),
        .iDisp_req     (iDisp_req),
        .iDisp_addr    (iDisp_addr),
        .oDisp_grant   (oDisp_grant),
        .oDisp_rvalid  (oDisp_rvalid),
        .oDisp_rdata   (oDisp_rdata),
        .iHost_wr      (iHost_wr),
        .iHost_addr    (iHost_addr),
        .iHost_wdata   (iHost_wdata),
        .oHost_ack     (oHost_ack),
        .oMem_req      (oMem_req),
        .oMem_we       (oMem_we),
        .oMem_addr     (oMem_addr),
        .oMem_wdata    (oMem_wdata),
        .iMem_ack      (iMem_ack),
        .iMem_rvalid   (iMem_rvalid),
        .iMem_rdata    (iMem_rdata)
    );

    cmd_t          cmd_q[$];
    logic [DW-1:0] data_q[$];
    logic [DW-1:0] ret_q[$];

    int   errors = 0;
    int   checks = 0;
    int   grant_cnt = 0;
    int   hack_cnt = 0;
    int   rd_acc = 0;
    int   rv_cnt = 0;
    int   drv_cnt = 0;
    int   out_model = 0;
    logic ack_en = 1'b0;
    logic ret_en = 1'b0;
    logic mon_en = 1'b0;
    logic fwd_prev = 1'b0;
    logic stall_prev = 1'b0;
    cmd_t held = '0;

    function automatic logic [DW-1:0] mem_data(input logic [AW:0] a);
        return a[15:0] ^ {a[22:16], 9'h0A5};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: ack level and in-order read returns for the current cycle.
    always @(posedge clk) begin
        #2;
        iMem_ack = ack_en;
        if (ret_en && ret_q.size() > 0) begin
            iMem_rvalid = 1'b1;
            iMem_rdata  = ret_q.pop_front();
        end else begin
            iMem_rvalid = 1'b0;
        end
    end

    // Monitor / scoreboard, mid-cycle.
    always @(negedge clk) begin
        logic acc;
        cmd_t e;
        if (mon_en) begin
            if (oDisp_rvalid || fwd_prev) begin
                chk("rvalid_timing", oDisp_rvalid, fwd_prev);
                if (oDisp_rvalid) begin
                    drv_cnt++;
                    chk("rdata_expected", data_q.size() != 0, 1);
                    if (data_q.size() != 0) chk("rdata", oDisp_rdata, data_q.pop_front());
                end
            end
            if (stall_prev) begin
                chk("hold_req", oMem_req, 1);
                chk("hold_we", oMem_we, held.we);
                chk("hold_addr", oMem_addr, held.addr);
                chk("hold_wdata", oMem_wdata, held.wdata);
            end
            acc = oMem_req && iMem_ack && iRST_N;
            if (acc) begin
                chk("cmd_expected", cmd_q.size() != 0, 1);
                if (cmd_q.size() != 0) begin
                    e = cmd_q.pop_front();
                    chk("cmd_we", oMem_we, e.we);
                    chk("cmd_addr", oMem_addr, e.addr);
                    if (e.we) chk("cmd_wdata", oMem_wdata, e.wdata);
                end
                if (!oMem_we) begin
                    ret_q.push_back(mem_data(oMem_addr));
                    rd_acc++;
                end
            end
            if (oHost_ack || (acc && oMem_we)) chk("host_ack_on_write", oHost_ack, acc && oMem_we);
            if (oHost_ack) hack_cnt++;
            if (oDisp_grant) grant_cnt++;
            if (iMem_rvalid) rv_cnt++;
            fwd_prev = iRST_N && iMem_rvalid && (out_model > 0);
            if (!iRST_N) begin
                out_model = 0;
            end else begin
                if (acc && !oMem_we) out_model++;
                if (iMem_rvalid && out_model > 0 && !(acc && !oMem_we && out_model == 1)) begin
                    out_model--;
                end else if (iMem_rvalid && acc && !oMem_we && out_model == 1 && fwd_prev) begin
                    out_model--;
                end
            end
            stall_prev = iRST_N && oMem_req && !iMem_ack;
            held = '{we: oMem_we, addr: oMem_addr, wdata: oMem_wdata};
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_burst(input logic front, input logic [AW-1:0] start);
        for (int i = 0; i < int'(BL); i++) begin
            logic [AW-1:0] off;
            off = start + AW'(i);
            cmd_q.push_back('{we: 1'b0, addr: {front, off}, wdata: '0});
            data_q.push_back(mem_data({front, off}));
        end
    endtask

    task automatic wait_grant(input string name);
        int t;
        t = 0;
        while (!oDisp_grant && t < 100) begin
            tick(1);
            t++;
        end
        chk({"grant_", name}, oDisp_grant, 1);
        iDisp_req = 1'b0;
    endtask

    task automatic wait_cmds(input string name);
        int t;
        t = 0;
        while (cmd_q.size() != 0 && t < 200) begin
            tick(1);
            t++;
        end
        chk({"cmds_", name}, cmd_q.size(), 0);
    endtask

    task automatic wait_drain(input string name);
        int   t;
        logic done;
        t    = 0;
        done = 1'b0;
        while (!done && t < 300) begin
            tick(1);
            t++;
            done = (cmd_q.size() == 0) && (data_q.size() == 0) && (ret_q.size() == 0)
                   && (out_model == 0);
        end
        chk({"drain_", name}, done, 1);
        tick(2);
    endtask

    task automatic wait_hack(input int base, input string name);
        int t;
        t = 0;
        while (hack_cnt == base && t < 100) begin
            tick(1);
            t++;
        end
        iHost_wr = 1'b0;
        chk({"hack_", name}, hack_cnt - base, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int g0, h0, r0, rv0, dv0, t;

        // Reset values.
        tick(3);
        chk("rst_front", oFront, 0);
        chk("rst_mem_req", oMem_req, 0);
        chk("rst_pending", oSwap_pending, 0);
        chk("rst_grant", oDisp_grant, 0);
        chk("rst_rvalid", oDisp_rvalid, 0);
        chk("rst_host_ack", oHost_ack, 0);
        iRST_N = 1'b1;
        mon_en = 1'b1;
        ack_en = 1'b1;
        ret_en = 1'b1;
        tick(2);

        // Basic burst at 0x100 in buffer 0.
        exp_burst(1'b0, 22'h000100);
        g0 = grant_cnt;
        dv0 = drv_cnt;
        iDisp_addr = 22'h000100;
        iDisp_req = 1'b1;
        wait_grant("burst");
        wait_drain("burst");
        chk("burst_grants", grant_cnt - g0, 1);
        chk("burst_rvalids", drv_cnt - dv0, 8);

        // Display and host together: burst first, then write to back buffer.
        exp_burst(1'b0, 22'h0002A0);
        cmd_q.push_back('{we: 1'b1, addr: {1'b1, 22'h012345}, wdata: 16'hBEEF});
        h0 = hack_cnt;
        iDisp_addr  = 22'h0002A0;
        iHost_addr  = 22'h012345;
        iHost_wdata = 16'hBEEF;
        iDisp_req   = 1'b1;
        iHost_wr    = 1'b1;
        wait_grant("contention");
        wait_hack(h0, "contention");
        wait_drain("contention");

        // Swap deferred past an in-flight burst until all reads return.
        iSwap_req = 1'b1;
        tick(1);
        iSwap_req = 1'b0;
        chk("pending_set", oSwap_pending, 1);
        ret_en = 1'b0;
        exp_burst(1'b0, 22'h000040);
        r0 = rd_acc;
        iDisp_addr = 22'h000040;
        iDisp_req = 1'b1;
        wait_grant("swap");
        t = 0;
        while (rd_acc - r0 < 3 && t < 100) begin
            tick(1);
            t++;
        end
        iTopOfScreen = 1'b1;
        tick(1);
        iTopOfScreen = 1'b0;
        wait_cmds("swap");
        tick(5);
        chk("front_held", oFront, 0);
        chk("pending_held", oSwap_pending, 1);
        ret_en = 1'b1;
        wait_drain("swap");
        chk("front_swapped", oFront, 1);
        chk("pending_clear", oSwap_pending, 0);

        // Host write under backpressure; front is now 1, so back buffer is 0.
        ack_en = 1'b0;
        cmd_q.push_back('{we: 1'b1, addr: {1'b0, 22'h00ABCD}, wdata: 16'h1234});
        h0 = hack_cnt;
        iHost_addr  = 22'h00ABCD;
        iHost_wdata = 16'h1234;
        iHost_wr    = 1'b1;
        tick(1);
        tick(5);
        chk("bp_req", oMem_req, 1);
        chk("bp_we", oMem_we, 1);
        chk("bp_addr", oMem_addr, {1'b0, 22'h00ABCD});
        chk("bp_wdata", oMem_wdata, 16'h1234);
        chk("bp_no_ack", hack_cnt - h0, 0);
        ack_en = 1'b1;
        wait_hack(h0, "bp");
        tick(2);

        // Offset wrap inside buffer 1.
        exp_burst(1'b1, 22'h3FFFFC);
        iDisp_addr = 22'h3FFFFC;
        iDisp_req = 1'b1;
        wait_grant("wrap");
        wait_drain("wrap");

        // Credit limit: second burst waits until the first one's reads return.
        ret_en = 1'b0;
        exp_burst(1'b1, 22'h000500);
        iDisp_addr = 22'h000500;
        iDisp_req = 1'b1;
        wait_grant("credit_a");
        wait_cmds("credit_a");
        exp_burst(1'b1, 22'h000600);
        g0 = grant_cnt;
        iDisp_addr = 22'h000600;
        iDisp_req = 1'b1;
        tick(6);
        chk("credit_block", grant_cnt - g0, 0);
        rv0 = rv_cnt;
        ret_en = 1'b1;
        wait_grant("credit_b");
        chk("credit_returns", rv_cnt - rv0, 8);
        wait_drain("credit");

        // Reset after four acks of a burst; late returns must be dropped.
        ret_en = 1'b0;
        exp_burst(1'b1, 22'h000700);
        r0 = rd_acc;
        iDisp_addr = 22'h000700;
        iDisp_req = 1'b1;
        wait_grant("rst");
        t = 0;
        while (rd_acc - r0 < 4 && t < 100) begin
            tick(1);
            t++;
        end
        ack_en = 1'b0;
        iRST_N = 1'b0;
        cmd_q.delete();
        data_q.delete();
        chk("rst_acks", rd_acc - r0, 4);
        tick(2);
        iRST_N = 1'b1;
        chk("rst2_mem_req", oMem_req, 0);
        chk("rst2_front", oFront, 0);
        chk("rst2_pending", oSwap_pending, 0);
        chk("rst2_grant", oDisp_grant, 0);
        ack_en = 1'b1;
        dv0 = drv_cnt;
        rv0 = rv_cnt;
        ret_en = 1'b1;
        tick(10);
        chk("late_returns_seen", rv_cnt - rv0, 4);
        chk("late_rvalid", drv_cnt - dv0, 0);
        chk("rst2_no_req", oMem_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
